// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI constants and slave state encoding
package spi_pkg;
    localparam int   SPI_WIDTH = 8;
    localparam logic SPI_CPOL  = 1'b0;
    localparam logic SPI_CPHA  = 1'b0;
    typedef enum logic {IDLE, ACTIVE} state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: N-stage input synchronizer with registered rise/fall strobes
module spi_sync_edge #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync;
    logic prev;
    // synchronize the pin, then compare against the previous synchronized value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= {STAGES{INIT}};
            prev <= INIT;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            prev <= sync[STAGES-1];
            rise <= sync[STAGES-1] & ~prev;
            fall <= ~sync[STAGES-1] & prev;
        end
    end
endmodule

// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI mode-0 slave with byte-wide tx/rx ports
module spi_slave
    import spi_pkg::*;
#(
    parameter int WIDTH       = SPI_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             ss,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             frame_err
);
    localparam int CW = $clog2(WIDTH);
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] rx_shift, tx_shift, pend, rx_next;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic full, sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic act, start, frame_done, load, accept;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .d(sclk), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_ss (
        .clk(clk), .rst(rst), .d(ss), .rise(ss_rise), .fall(ss_fall)
    );

    // ss rise beats a coincident sclk edge, so "act" excludes it
    assign act        = (state == ACTIVE) && !ss_rise;
    assign start      = (state == IDLE) && ss_fall;
    assign frame_done = act && sclk_rise && (cnt == CW'(WIDTH - 1));
    assign load       = start | frame_done;
    assign accept     = tx_valid & ~full;
    assign tx_ready   = ~full;
    assign rx_next    = {rx_shift[WIDTH-2:0], mosi_sync[SYNC_STAGES-1]};

    // mosi only needs synchronizing; sclk edges decide when to sample it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mosi_sync <= '0;
        else      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // next-state: select opens a frame, deselect closes it
    always_comb begin
        state_n = (state == IDLE) ? (ss_fall ? ACTIVE : IDLE) : (ss_rise ? IDLE : ACTIVE);
    end

    // outputs: MISO is driven only while selected
    always_comb begin
        busy    = (state == ACTIVE);
        miso_oe = busy;
        miso    = busy & tx_shift[WIDTH-1];
    end

    // datapath: pending buffer, shifters, bit counter and strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            pend      <= '0;
            full      <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= frame_done;
            frame_err <= (state == ACTIVE) && ss_rise && (cnt != '0);
            pend      <= accept ? tx_data : pend;
            full      <= accept | (full & ~load);
            if (load)
                tx_shift <= full ? pend : '0;
            else if (act && !sclk_rise && sclk_fall && cnt != '0)
                tx_shift <= tx_shift << 1;
            if (start || ((state == ACTIVE) && ss_rise)) begin
                cnt <= '0;
            end else if (act && sclk_rise) begin
                cnt      <= frame_done ? '0 : cnt + 1'b1;
                rx_shift <= rx_next;
            end
            if (frame_done) rx_data <= rx_next;
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: scoreboard bench driving the slave with an emulated mode-0 master
module tb_spi_slave;
    logic clk = 1'b0, rst = 1'b0, sclk = 1'b0, ss = 1'b1, mosi = 1'b0;
    logic miso, miso_oe, tx_ready, rx_valid, busy, frame_err, tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00, rx_data, mi;
    logic [7:0] rxq[$], misoq[$];
    int checks = 0, failures = 0, rxv_cnt = 0, ferr_cnt = 0, r0, f0;

    spi_slave #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // scoreboard side: each received frame is popped against what was pushed
    always @(negedge clk) begin
        if (rx_valid) begin
            rxv_cnt++;
            if (rxq.size() != 0) chk("rx_data", rx_data, rxq.pop_front());
            else chk("rx_unexpected", rx_valid, 0);
        end
        if (frame_err) ferr_cnt++;
    end

    task automatic offer(input logic [7:0] b);
        int k;
        k = 0;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) chk("offer_timeout", tx_ready, 1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // master emulation: sclk half period of 6 clk, MISO sampled just before each rise
    task automatic bits(input logic [7:0] mo, input int n, output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi = mo[7-i];
            wait_clks(6);
            got  = {got[6:0], miso};
            sclk = 1'b1;
            if (i == 7) begin
                int k;
                k = 0;
                do begin
                    @(posedge clk);
                    #1;
                    k++;
                end while (!rx_valid && k < 12);
                chk("rxv_latency", k, 4);
                wait_clks(3);
            end else begin
                wait_clks(6);
            end
            sclk = 1'b0;
        end
        wait_clks(6);
    endtask

    task automatic xfer(input logic [7:0] mo);
        logic [7:0] got;
        bits(mo, 8, got);
        chk("miso_byte", got, misoq.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        wait_clks(3);
        chk("rst_miso", miso, 0);
        chk("rst_miso_oe", miso_oe, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_err", frame_err, 0);
        rst = 1'b1;
        wait_clks(5);

        offer(8'hA5);
        chk("tx_ready_full", tx_ready, 0);
        misoq.push_back(8'hA5);
        rxq.push_back(8'h3C);
        ss = 1'b0;
        wait_clks(6);
        chk("busy_active", busy, 1);
        chk("oe_active", miso_oe, 1);
        xfer(8'h3C);
        ss = 1'b1;
        wait_clks(8);
        chk("busy_idle", busy, 0);
        chk("oe_idle", miso_oe, 0);

        misoq.push_back(8'h00);
        rxq.push_back(8'hFF);
        ss = 1'b0;
        wait_clks(6);
        xfer(8'hFF);
        ss = 1'b1;
        wait_clks(8);

        offer(8'h55);
        ss = 1'b0;
        wait_clks(6);
        offer(8'hAA);
        misoq.push_back(8'h55);
        misoq.push_back(8'hAA);
        rxq.push_back(8'h12);
        rxq.push_back(8'h34);
        xfer(8'h12);
        xfer(8'h34);
        ss = 1'b1;
        wait_clks(8);
        chk("rxv_total", rxv_cnt, 4);

        r0 = rxv_cnt;
        f0 = ferr_cnt;
        ss = 1'b0;
        wait_clks(6);
        bits(8'hF0, 5, mi);
        ss = 1'b1;
        wait_clks(8);
        chk("abort_ferr", ferr_cnt - f0, 1);
        chk("abort_rxv", rxv_cnt - r0, 0);
        chk("abort_rx_data", rx_data, 8'h34);
        chk("abort_oe", miso_oe, 0);

        offer(8'hC3);
        ss = 1'b0;
        wait_clks(6);
        offer(8'h99);
        bits(8'h00, 3, mi);
        chk("mid_tx_ready", tx_ready, 0);
        rst = 1'b0;
        #1;
        chk("mid_rst_oe", miso_oe, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tx_ready", tx_ready, 1);
        chk("mid_rst_rx_data", rx_data, 0);
        chk("mid_rst_miso", miso, 0);
        ss = 1'b1;
        wait_clks(2);
        rst = 1'b1;
        wait_clks(5);
        chk("post_rst_tx_ready", tx_ready, 1);

        misoq.push_back(8'h00);
        rxq.push_back(8'h5A);
        ss = 1'b0;
        wait_clks(6);
        xfer(8'h5A);
        ss = 1'b1;
        wait_clks(8);

        chk("rxq_drained", rxq.size(), 0);
        chk("misoq_drained", misoq.size(), 0);
        chk("ferr_total", ferr_cnt, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_slave.md
# spi_slave

SPI mode-0 slave that receives MSB-first frames from `spi_master` and returns a response frame on MISO. It oversamples SCLK, SS and MOSI in the local `clk` domain and offers a byte-wide valid/ready transmit port and a pulse-qualified receive port to the core logic. It is the far-end peer used by the system's peripheral side and by the master's loopback bench.

## Interface
- `WIDTH`, 8: frame length in bits; matches the master's 8-bit shift register.
- `SYNC_STAGES`, 2: flops in each input synchronizer (≥2).
- `clk`  in  1  system clock; must run ≥4× the SCLK frequency.
- `rst`  in  1  reset; asynchronous, active-low; deassertion is synchronous to `clk` externally.
- `sclk`  in  1  SPI clock from master; idles low.
- `ss`  in  1  slave select, active-low; idles high.
- `mosi`  in  1  serial data from master, changes on SCLK falling edge.
- `miso`  out  1  serial data to master, valid before each SCLK rising edge.
- `miso_oe`  out  1  output enable for the MISO pad driver; high only while selected.
- `tx_data`  in  WIDTH  response byte.
- `tx_valid`  in  1  `tx_data` is offered.
- `tx_ready`  out  1  pending-byte buffer empty; transfer occurs when `tx_valid && tx_ready`.
- `rx_data`  out  WIDTH  last complete received frame.
- `rx_valid`  out  1  one-cycle pulse: `rx_data` updated.
- `busy`  out  1  frame in progress (state ACTIVE).
- `frame_err`  out  1  one-cycle pulse: SS released with a partial frame.

## Operation
- Reset values: `miso`=0, `miso_oe`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `busy`=0, `frame_err`=0; state IDLE, bit counter 0, shift registers 0, pending buffer empty.
- Synchronizers: `sclk`, `ss`, `mosi` each pass `SYNC_STAGES` flops; one further flop on sclk/ss gives edge detect (sclk rise, sclk fall, ss fall, ss rise).
- Pending buffer: one WIDTH register plus full flag; `tx_ready` = !full. Accepting a byte sets full; loading it into the TX shifter clears full.
- States: IDLE and ACTIVE.
- IDLE → ACTIVE on ss fall: TX shifter ← pending byte if full (full cleared), else all-zeros; bit counter ← 0; `miso_oe`=1; `miso` = TX shifter MSB.
- ACTIVE, sclk rise: RX shifter ← {RX[WIDTH-2:0], mosi_sync}; counter +1. When counter reaches WIDTH: `rx_data` ← completed RX value, `rx_valid` pulses next cycle, counter wraps to 0, TX shifter reloads from pending buffer (or zeros) as on frame start.
- ACTIVE, sclk fall (counter ≠ 0): TX shifter shifts left by one; `miso` = new MSB.
- ACTIVE → IDLE on ss rise: counter ≠ 0 → partial frame discarded, `frame_err` pulses, `rx_data` unchanged; counter = 0 → clean end. `miso_oe`=0, `miso`=0.
- Simultaneous ss rise and sclk rise in the same sampled cycle: ss rise wins; the edge is ignored.
- SCLK edges while IDLE are ignored. Pending buffer is never cleared by SS activity, only by loading.
- Reset asserted mid-frame: all state returns to reset values immediately; pending byte is lost.

## Timing
- Input-to-detect latency: `SYNC_STAGES`+1 clk cycles from a pin edge to the internal edge strobe.
- `rx_valid` asserts exactly `SYNC_STAGES`+2 clk cycles after the WIDTH-th SCLK rising edge at the pin.
- `miso` updates `SYNC_STAGES`+2 clk cycles after an SCLK falling edge or SS falling edge; the ≥4× clock ratio guarantees setup before the next rising edge.
- Back-to-back frames with SS held low are supported without gap; the reloaded MSB appears on the same cycle as the `rx_valid` pulse.
- `tx_valid`/`tx_ready` handshake is fully synchronous; `tx_ready` may rise in the same cycle as a load and a new byte may be accepted the following cycle.

## Structure
- Shared package `spi_pkg`: state enum (IDLE, ACTIVE), default `WIDTH` constant shared with `spi_master`, SPI mode constants.
- One sub-module: `spi_sync_edge` (N-stage synchronizer plus rise/fall strobes), instantiated for sclk and ss; mosi uses the synchronizer path only.

## Test plan
- Reset: `rst`=0 mid-operation → all outputs at reset values within the same cycle; `tx_ready`=1 after release.
- Single frame: preload `tx_data`=0xA5, master sends 0x3C → `rx_data`=0x3C with one `rx_valid` pulse; master samples 0xA5 on MISO.
- Underrun: no byte preloaded, master sends 0xFF → MISO returns 0x00, `rx_data`=0xFF.
- Back-to-back: SS low for two frames 0x12, 0x34 with 0x55, 0xAA queued in time → two `rx_valid` pulses, MISO returns 0x55 then 0xAA.
- Abort: SS released after 5 SCLK rises → `frame_err` one pulse, no `rx_valid`, `rx_data` keeps prior value, `miso_oe`=0.
- Loopback with `spi_master` (SCLK = clk/4): `data_in`=0x2A → slave `rx_data`=0x2A, `done` from master after `rx_valid`.
